// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the default operand width.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int DEF_DATA_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: a - b - borrow_in.
module full_subtractor (
   input  logic Data_A_In,
   input  logic Data_B_In,
   input  logic Borrow_In,
   output logic Difference_Out,
   output logic Borrow_Out
);

   logic w_axb;

   assign w_axb          = Data_A_In ^ Data_B_In;
   assign Difference_Out = w_axb ^ Borrow_In;
   assign Borrow_Out     = (~Data_A_In & Data_B_In) | (~w_axb & Borrow_In);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, through a
// single full_subtractor cell. Start/Ready in, Valid/Ack out.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  Clock_In,
   input  logic                  Reset_In,
   input  logic                  Start_In,
   output logic                  Ready_Out,
   input  logic [DATA_WIDTH-1:0] Data_A_In,
   input  logic [DATA_WIDTH-1:0] Data_B_In,
   output logic [DATA_WIDTH-1:0] Difference_Out,
   output logic                  Borrow_Out,
   output logic                  Valid_Out,
   input  logic                  Result_Ack_In
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   state_t                r_state;
   state_t                w_next;
   logic [DATA_WIDTH-1:0] r_a;
   logic [DATA_WIDTH-1:0] r_b;
   logic [DATA_WIDTH-1:0] r_res;
   logic [DATA_WIDTH-1:0] r_diff;
   logic                  r_br;
   logic                  r_borrow;
   logic [CW-1:0]         r_cnt;
   logic                  w_d;
   logic                  w_bout;
   logic                  w_accept;
   logic                  w_last;

   full_subtractor u_cell (
      .Data_A_In      (r_a[0]),
      .Data_B_In      (r_b[0]),
      .Borrow_In      (r_br),
      .Difference_Out (w_d),
      .Borrow_Out     (w_bout)
   );

   assign w_accept = Start_In & (r_state == ST_IDLE);
   assign w_last   = (r_cnt == LAST_BIT);

   always_ff @(posedge Clock_In or posedge Reset_In) begin
      if (Reset_In) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (Start_In)      w_next = ST_SHIFT;
         ST_SHIFT: if (w_last)        w_next = ST_DONE;
         ST_DONE:  if (Result_Ack_In) w_next = ST_IDLE;
         default:                     w_next = ST_IDLE;
      endcase
   end

   // Datapath only moves while shifting; the output registers load solely on
   // the final bit so they hold the last result through DONE and after Ack.
   always_ff @(posedge Clock_In or posedge Reset_In) begin
      if (Reset_In) begin
         r_a      <= '0;
         r_b      <= '0;
         r_res    <= '0;
         r_br     <= 1'b0;
         r_cnt    <= '0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
      end else if (w_accept) begin
         r_a   <= Data_A_In;
         r_b   <= Data_B_In;
         r_br  <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == ST_SHIFT) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_br  <= w_bout;
         r_res <= {w_d, r_res[DATA_WIDTH-1:1]};
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_diff   <= {w_d, r_res[DATA_WIDTH-1:1]};
            r_borrow <= w_bout;
         end
      end
   end

   assign Ready_Out      = (r_state == ST_IDLE);
   assign Valid_Out      = (r_state == ST_DONE);
   assign Difference_Out = r_diff;
   assign Borrow_Out     = r_borrow;

endmodule
